// File: rtl/signal_generator_ext_if.sv
// Stream and configuration bundle for one DAC channel of the DDS post-processor.
// The driver (DDS side and config master) uses master; the generator uses slave.
interface signal_generator_ext_if #(
    parameter int AXIS_TDATA_WIDTH       = 16,
    parameter int AXIS_TDATA_PHASE_WIDTH = 16,
    parameter int DAC_WIDTH              = 14,
    parameter int SCALE_WIDTH            = 16
);
    logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata;
    logic                              s_axis_tvalid;
    logic [AXIS_TDATA_PHASE_WIDTH-1:0] s_axis_tdata_phase;
    logic                              s_axis_tvalid_phase;
    logic [2:0]                        cfg_mode;
    logic [SCALE_WIDTH-1:0]            cfg_amplitude;
    logic [DAC_WIDTH-1:0]              cfg_offset;
    logic [AXIS_TDATA_PHASE_WIDTH-1:0] cfg_duty;
    logic                              cfg_valid;
    logic                              cfg_pending;
    logic [AXIS_TDATA_WIDTH-1:0]       m_axis_tdata;
    logic                              m_axis_tvalid;
    logic                              sat;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tdata_phase, s_axis_tvalid_phase,
        output cfg_mode, cfg_amplitude, cfg_offset, cfg_duty, cfg_valid,
        input  cfg_pending, m_axis_tdata, m_axis_tvalid, sat
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tdata_phase, s_axis_tvalid_phase,
        input  cfg_mode, cfg_amplitude, cfg_offset, cfg_duty, cfg_valid,
        output cfg_pending, m_axis_tdata, m_axis_tvalid, sat
    );
endinterface

// File: rtl/signal_generator_ext.sv
// Per-channel DDS post-processor: waveform synthesis, gain, offset and clamp for the DAC path.
// Configuration is double-buffered and swapped in only on a phase wrap beat.
module signal_generator_ext #(
    parameter int AXIS_TDATA_WIDTH       = 16,
    parameter int AXIS_TDATA_PHASE_WIDTH = 16,
    parameter int DAC_WIDTH              = 14,
    parameter int SCALE_WIDTH            = 16
) (
    input logic                   clk,
    input logic                   reset,
    signal_generator_ext_if.slave bus
);
    // state      | meaning
    // ST_APPLIED | active config in use, nothing waiting in the shadow
    // ST_PENDING | shadow captured, copied to active on the next wrap beat

    localparam int D  = DAC_WIDTH;
    localparam int S  = SCALE_WIDTH;
    localparam int PW = AXIS_TDATA_PHASE_WIDTH;
    localparam int P  = D + S + 1;

    localparam logic [D-1:0] L_POS_FS = {1'b0, {(D-1){1'b1}}};
    localparam logic [D-1:0] L_NEG_FS = {1'b1, {(D-2){1'b0}}, 1'b1};
    localparam logic [D-1:0] L_MIN    = {1'b1, {(D-1){1'b0}}};
    localparam logic signed [P-1:0] L_SUM_HI = $signed({{(P-D+1){1'b0}}, {(D-1){1'b1}}});
    localparam logic signed [P-1:0] L_SUM_LO = $signed({{(P-D+1){1'b1}}, {(D-1){1'b0}}});

    typedef enum logic {ST_APPLIED, ST_PENDING} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_prev_phase;
    logic [2:0]      r_act_mode,   r_sh_mode;
    logic [S-1:0]    r_act_amp,    r_sh_amp;
    logic [D-1:0]    r_act_offset, r_sh_offset;
    logic [PW-1:0]   r_act_duty,   r_sh_duty;

    logic            w_beat;
    logic            w_wrap;
    logic            w_apply;
    logic [2:0]      w_cur_mode;
    logic [S-1:0]    w_cur_amp;
    logic [D-1:0]    w_cur_offset;
    logic [PW-1:0]   w_cur_duty;
    logic            w_unused_tdata;

    assign w_beat  = bus.s_axis_tvalid & bus.s_axis_tvalid_phase;
    assign w_wrap  = w_beat && (bus.s_axis_tdata_phase < r_prev_phase);
    // A cfg_valid coinciding with the wrap keeps the shadow pending instead of applying it.
    assign w_apply = (r_state == ST_PENDING) && w_wrap && !bus.cfg_valid;

    assign w_cur_mode   = w_apply ? r_sh_mode   : r_act_mode;
    assign w_cur_amp    = w_apply ? r_sh_amp    : r_act_amp;
    assign w_cur_offset = w_apply ? r_sh_offset : r_act_offset;
    assign w_cur_duty   = w_apply ? r_sh_duty   : r_act_duty;

    assign w_unused_tdata  = ^bus.s_axis_tdata[AXIS_TDATA_WIDTH-1:D];
    assign bus.cfg_pending = (r_state == ST_PENDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_APPLIED;
            r_prev_phase <= '0;
            r_act_mode   <= bus.cfg_mode;
            r_act_amp    <= bus.cfg_amplitude;
            r_act_offset <= bus.cfg_offset;
            r_act_duty   <= bus.cfg_duty;
            r_sh_mode    <= '0;
            r_sh_amp     <= '0;
            r_sh_offset  <= '0;
            r_sh_duty    <= '0;
        end else begin
            if (w_beat) begin
                r_prev_phase <= bus.s_axis_tdata_phase;
            end
            if (bus.cfg_valid) begin
                r_sh_mode   <= bus.cfg_mode;
                r_sh_amp    <= bus.cfg_amplitude;
                r_sh_offset <= bus.cfg_offset;
                r_sh_duty   <= bus.cfg_duty;
            end
            case (r_state)
                ST_APPLIED: begin
                    if (bus.cfg_valid) begin
                        r_state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_apply) begin
                        r_act_mode   <= r_sh_mode;
                        r_act_amp    <= r_sh_amp;
                        r_act_offset <= r_sh_offset;
                        r_act_duty   <= r_sh_duty;
                        r_state      <= ST_APPLIED;
                    end
                end
                default: r_state <= ST_APPLIED;
            endcase
        end
    end

    logic                r_s1_valid;
    logic [D-1:0]        r_s1_sample;
    logic [PW-1:0]       r_s1_phase;
    logic [2:0]          r_s1_mode;
    logic [S-1:0]        r_s1_amp;
    logic [D-1:0]        r_s1_offset;
    logic [PW-1:0]       r_s1_duty;

    logic                r_s2_valid;
    logic signed [D-1:0] r_s2_wave;
    logic                r_s2_zero;
    logic [S-1:0]        r_s2_amp;
    logic signed [D-1:0] r_s2_offset;

    logic                r_s3_valid;
    logic signed [P-1:0] r_s3_scaled;
    logic                r_s3_zero;
    logic signed [D-1:0] r_s3_offset;

    logic                r_out_valid;
    logic signed [D-1:0] r_out_data;
    logic                r_sat;

    logic [D-1:0]        w_u;
    logic [D-1:0]        w_u_dbl;
    logic [D-1:0]        w_wave;
    logic signed [P-1:0] w_prod;
    logic signed [P-1:0] w_sum;

    assign w_u     = r_s1_phase[PW-1 -: D];
    assign w_u_dbl = {w_u[D-2:0], 1'b0};

    // Triangle is evaluated modulo 2^D; both halves fit in signed D bits, so the wrap is exact.
    always_comb begin
        w_wave = '0;
        case (r_s1_mode)
            3'd0:    w_wave = r_s1_sample;
            3'd1:    w_wave = (w_u == L_MIN) ? L_POS_FS : ((~w_u) + D'(1));
            3'd2:    w_wave = w_u[D-1] ? (L_POS_FS - w_u_dbl) : (w_u_dbl ^ L_MIN);
            3'd3:    w_wave = w_u;
            3'd4:    w_wave = (r_s1_phase < r_s1_duty) ? L_POS_FS : L_NEG_FS;
            default: w_wave = '0;
        endcase
    end

    assign w_prod = P'(r_s2_wave) * $signed(P'(r_s2_amp));
    assign w_sum  = r_s3_scaled + P'(r_s3_offset);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_phase  <= '0;
            r_s1_mode   <= '0;
            r_s1_amp    <= '0;
            r_s1_offset <= '0;
            r_s1_duty   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_wave   <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_amp    <= '0;
            r_s2_offset <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_scaled <= '0;
            r_s3_zero   <= 1'b0;
            r_s3_offset <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_s1_valid  <= w_beat;
            r_s1_sample <= bus.s_axis_tdata[D-1:0];
            r_s1_phase  <= bus.s_axis_tdata_phase;
            r_s1_mode   <= w_cur_mode;
            r_s1_amp    <= w_cur_amp;
            r_s1_offset <= w_cur_offset;
            r_s1_duty   <= w_cur_duty;

            r_s2_valid  <= r_s1_valid;
            r_s2_wave   <= w_wave;
            r_s2_zero   <= r_s1_mode[2] & r_s1_mode[1];
            r_s2_amp    <= r_s1_amp;
            r_s2_offset <= r_s1_offset;

            r_s3_valid  <= r_s2_valid;
            r_s3_scaled <= w_prod >>> (S-1);
            r_s3_zero   <= r_s2_zero;
            r_s3_offset <= r_s2_offset;

            r_out_valid <= r_s3_valid;
            if (r_s3_zero) begin
                r_out_data <= '0;
                r_sat      <= 1'b0;
            end else if (w_sum > L_SUM_HI) begin
                r_out_data <= L_POS_FS;
                r_sat      <= 1'b1;
            end else if (w_sum < L_SUM_LO) begin
                r_out_data <= L_MIN;
                r_sat      <= 1'b1;
            end else begin
                r_out_data <= w_sum[D-1:0];
                r_sat      <= 1'b0;
            end
        end
    end

    assign bus.m_axis_tdata  = AXIS_TDATA_WIDTH'(r_out_data);
    assign bus.m_axis_tvalid = r_out_valid;
    assign bus.sat           = r_sat;
endmodule

// File: tb/tb_signal_generator_ext.sv
// Directed bench for signal_generator_ext: every cycle's expectation is queued and compared
// exactly four cycles later, so latency, valid gaps and data are all checked together.
module tb_signal_generator_ext;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    signal_generator_ext_if bus ();

    signal_generator_ext dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic        chkd;
        logic [15:0] d;
        logic        s;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic sv, input logic pv, input logic [15:0] ph,
                        input logic chkd, input logic [15:0] ed, input logic es);
        exp_t e;
        bus.s_axis_tvalid       = sv;
        bus.s_axis_tvalid_phase = pv;
        bus.s_axis_tdata_phase  = ph;
        e.v    = sv & pv;
        e.chkd = chkd;
        e.d    = ed;
        e.s    = es;
        e.cyc  = cycle;
        q.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        bus.cfg_valid = 1'b0;
        if (q.size() == 4) begin
            e = q.pop_front();
            check($sformatf("valid@%0d", e.cyc), {15'd0, bus.m_axis_tvalid}, {15'd0, e.v});
            if (e.chkd) begin
                check($sformatf("data@%0d", e.cyc), bus.m_axis_tdata, e.d);
                check($sformatf("sat@%0d", e.cyc), {15'd0, bus.sat}, {15'd0, e.s});
            end
        end
    endtask

    task automatic beat(input logic [15:0] ph, input logic [15:0] ed, input logic es);
        step(1'b1, 1'b1, ph, 1'b1, ed, es);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic drain();
        repeat (4) idle();
    endtask

    task automatic do_reset(input logic [2:0] m, input logic [15:0] a,
                            input logic [13:0] o, input logic [15:0] du);
        exp_t z;
        z = '{v: 1'b0, chkd: 1'b1, d: 16'h0000, s: 1'b0, cyc: -1};
        bus.cfg_mode      = m;
        bus.cfg_amplitude = a;
        bus.cfg_offset    = o;
        bus.cfg_duty      = du;
        bus.cfg_valid     = 1'b0;
        reset = 1'b1;
        q.delete();
        repeat (3) q.push_back(z);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        check("rst_pending", {15'd0, bus.cfg_pending}, 16'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset                   = 1'b1;
        bus.s_axis_tdata        = 16'h0000;
        bus.s_axis_tvalid       = 1'b0;
        bus.s_axis_tdata_phase  = 16'h0000;
        bus.s_axis_tvalid_phase = 1'b0;
        bus.cfg_mode            = 3'd3;
        bus.cfg_amplitude       = 16'h8000;
        bus.cfg_offset          = 14'd0;
        bus.cfg_duty            = 16'h0000;
        bus.cfg_valid           = 1'b0;

        // sawtooth, unity gain
        do_reset(3'd3, 16'h8000, 14'd0, 16'h0000);
        beat(16'h0000, 16'h0000, 1'b0);
        beat(16'h4000, 16'h1000, 1'b0);
        beat(16'h8000, 16'hE000, 1'b0);
        beat(16'hC000, 16'hF000, 1'b0);
        drain();

        // near-double gain: clip both ways, truncation toward -inf
        do_reset(3'd3, 16'hFFFF, 14'd0, 16'h0000);
        beat(16'h7FFC, 16'h1FFF, 1'b1);
        beat(16'h8000, 16'hE000, 1'b1);
        beat(16'h0100, 16'h007F, 1'b0);
        drain();

        // offset
        do_reset(3'd3, 16'h8000, 14'd100, 16'h0000);
        beat(16'h8000, 16'hE064, 1'b0);
        beat(16'h7FFC, 16'h1FFF, 1'b1);
        drain();

        // square
        do_reset(3'd4, 16'h8000, 14'd0, 16'h4000);
        beat(16'h3FFF, 16'h1FFF, 1'b0);
        beat(16'h4000, 16'hE001, 1'b0);
        drain();

        // triangle
        do_reset(3'd2, 16'h8000, 14'd0, 16'h0000);
        beat(16'h0000, 16'hE000, 1'b0);
        beat(16'h4000, 16'h0000, 1'b0);
        beat(16'h8000, 16'h1FFF, 1'b0);
        beat(16'hC000, 16'hFFFF, 1'b0);
        drain();

        // sine passthrough, upper input bits ignored
        do_reset(3'd0, 16'h8000, 14'd0, 16'h0000);
        bus.s_axis_tdata = 16'h7ABC;
        beat(16'h1234, 16'hFABC, 1'b0);
        bus.s_axis_tdata = 16'h1000;
        beat(16'h2234, 16'h1000, 1'b0);
        drain();
        bus.s_axis_tdata = 16'h0000;

        // DC and zero modes
        do_reset(3'd5, 16'h8000, 14'd100, 16'h0000);
        beat(16'h1234, 16'h0064, 1'b0);
        drain();
        do_reset(3'd6, 16'h8000, 14'd100, 16'h0000);
        beat(16'h9000, 16'h0000, 1'b0);
        drain();
        do_reset(3'd7, 16'hFFFF, 14'h1FFF, 16'h0000);
        beat(16'h9000, 16'h0000, 1'b0);
        drain();

        // half gain
        do_reset(3'd3, 16'h4000, 14'd0, 16'h0000);
        beat(16'h4000, 16'h0800, 1'b0);
        beat(16'h8004, 16'hF000, 1'b0);
        drain();

        // deferred config: mode 1 captured mid-period, applied at the wrap
        do_reset(3'd3, 16'h8000, 14'd0, 16'h0000);
        for (int ph = 'h1FF0; ph <= 'hFFFC; ph += 4) begin
            if (ph == 'h2000) begin
                bus.cfg_mode  = 3'd1;
                bus.cfg_valid = 1'b1;
            end
            step(1'b1, 1'b1, 16'(ph),
                 (ph == 'h2000) || (ph == 'h8000) || (ph == 'hFFFC),
                 (ph == 'h2000) ? 16'h0800 : ((ph == 'h8000) ? 16'hE000 : 16'hFFFF), 1'b0);
            if (ph == 'h2000) check("pending_rise", {15'd0, bus.cfg_pending}, 16'd1);
        end
        check("pending_prewrap", {15'd0, bus.cfg_pending}, 16'd1);
        beat(16'h0000, 16'h0000, 1'b0);
        check("pending_fall", {15'd0, bus.cfg_pending}, 16'd0);
        beat(16'h0004, 16'hFFFF, 1'b0);
        beat(16'h0008, 16'hFFFE, 1'b0);

        // collision: second cfg_valid on the wrap beat keeps mode 1 for another period
        bus.cfg_mode  = 3'd2;
        bus.cfg_valid = 1'b1;
        beat(16'h4000, 16'hF000, 1'b0);
        check("coll_pending_a", {15'd0, bus.cfg_pending}, 16'd1);
        beat(16'h8000, 16'h1FFF, 1'b0);
        bus.cfg_mode  = 3'd3;
        bus.cfg_valid = 1'b1;
        beat(16'h0100, 16'hFFC0, 1'b0);
        check("coll_pending_b", {15'd0, bus.cfg_pending}, 16'd1);
        beat(16'h4000, 16'hF000, 1'b0);
        beat(16'h8000, 16'h1FFF, 1'b0);
        check("coll_pending_c", {15'd0, bus.cfg_pending}, 16'd1);
        beat(16'h0100, 16'h0040, 1'b0);
        check("coll_pending_d", {15'd0, bus.cfg_pending}, 16'd0);
        beat(16'h4000, 16'h1000, 1'b0);

        // valid gaps
        beat(16'h5000, 16'h1400, 1'b0);
        repeat (3) step(1'b1, 1'b0, 16'h5400, 1'b0, 16'h0000, 1'b0);
        beat(16'h6000, 16'h1800, 1'b0);
        step(1'b0, 1'b1, 16'h6800, 1'b0, 16'h0000, 1'b0);
        beat(16'h7000, 16'h1C00, 1'b0);

        // reset mid-stream with a pending shadow
        bus.cfg_mode  = 3'd1;
        bus.cfg_valid = 1'b1;
        step(1'b1, 1'b1, 16'h7C00, 1'b0, 16'h0000, 1'b0);
        check("mid_pending", {15'd0, bus.cfg_pending}, 16'd1);
        step(1'b1, 1'b1, 16'h7D00, 1'b0, 16'h0000, 1'b0);
        do_reset(3'd3, 16'h8000, 14'd0, 16'h0000);
        idle();
        idle();
        beat(16'h4000, 16'h1000, 1'b0);
        beat(16'h0100, 16'h0040, 1'b0);
        check("post_rst_pending", {15'd0, bus.cfg_pending}, 16'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
